shift_reg_ctrl: RTL and testbench
=================================

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one word.
REQ-002 SHALL have parameter LENGTH, default 4: number of words in the controlled shift register (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_op  input  2  opcode: 0 LOAD, 1 DRAIN, 2 FILL, 3 illegal.
REQ-007 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-008 SHALL have port wr_valid / wr_data  input  1 / DATA_WIDTH  FILL word stream.
REQ-009 SHALL have port wr_ready  output  1  FILL word accepted when wr_valid&&wr_ready.
REQ-010 SHALL have port rd_valid / rd_data  output  1 / DATA_WIDTH  DRAIN word stream; no backpressure.
REQ-011 SHALL have port done  output  1  one-cycle pulse on command completion.
REQ-012 SHALL have port err  output  1  one-cycle pulse on illegal opcode.
REQ-013 SHALL have port sr_ctrl_code  output  2  to shift register: 0 UPLOAD, 1 LOAD, 2 WRITE, 3 READ.
REQ-014 SHALL have port sr_data_write  output  DATA_WIDTH  to shift register write data.
REQ-015 SHALL have port sr_data_read  input  DATA_WIDTH  from shift register read data (registered there, valid one cycle after READ).
REQ-016 SHALL have port sr_en  input  1  shift register enable; codes are ignored while low.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, DRAIN, DRAIN_LAST, FILL, UPLD.
REQ-018 In IDLE, cmd_ready=1 and sr_ctrl_code=0 (UPLOAD, the idle code); cmd_valid&&cmd_ready captures cmd_op: 0->LOAD, 1->DRAIN, 2->FILL, 3->IDLE.
REQ-019 LOAD: sr_ctrl_code=1 for one cycle with sr_en=1 (held while sr_en=0), then IDLE.
REQ-020 DRAIN: sr_ctrl_code=3; counter cnt ($clog2(LENGTH) bits) increments on each cycle with sr_en=1; after LENGTH such cycles -> DRAIN_LAST.
REQ-021 rd_valid SHALL be registered, high exactly one cycle after each DRAIN cycle with sr_en=1; rd_data = sr_data_read; exactly LENGTH pulses per DRAIN, contents[0] first.
REQ-022 DRAIN_LAST: sr_ctrl_code=0 for one cycle (carries last rd_valid), then IDLE.
REQ-023 FILL: wr_ready=sr_en; sr_data_write=wr_data; sr_ctrl_code=2 when wr_valid&&sr_en, else 0; cnt increments per handshake; after LENGTH handshakes -> UPLD.
REQ-024 UPLD: sr_ctrl_code=0 for one cycle with sr_en=1, then IDLE.
REQ-025 done SHALL pulse high the cycle after LOAD, DRAIN_LAST or UPLD exits to IDLE; never on illegal opcode.
REQ-026 cnt SHALL clear on every IDLE entry; no wrap beyond LENGTH-1 within a command.
REQ-027 wr_ready=0 and rd_valid=0 outside FILL/DRAIN(+1 cycle); cmd_valid outside IDLE SHALL be ignored.
REQ-028 sr_ctrl_code, sr_data_write, wr_ready, cmd_ready SHALL be combinational from state and inputs; done, err, rd_valid registered.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, cnt=0, done=0, err=0, rd_valid=0, rd_data=0, regardless of state.
REQ-030 Reset mid-command SHALL abort it without done; first cycle after release is IDLE with cmd_ready=1.

Configuration
REQ-031 Macro SHIFT_REG_CTRL_ERR_EN defined: op 3 accepted, err pulses one cycle after acceptance, FSM stays IDLE.
REQ-032 Macro undefined: op 3 accepted and silently dropped; err tied 0; no other behaviour changes.

Verification
REQ-033 LENGTH=4, sr_en=1: cmd LOAD -> sr_ctrl_code=1 one cycle, done next cycle, cmd_ready back.
REQ-034 Preload A,B,C,D; cmd DRAIN -> READ 4 cycles, rd_valid 4 pulses with rd_data A,B,C,D, done after DRAIN_LAST.
REQ-035 cmd FILL, wr_valid toggling 1,0,1,1,0,1 with 11,22,33,44 -> WRITE only on handshakes, then UPLOAD, done; DRAIN returns 11,22,33,44.
REQ-036 sr_en low 3 cycles mid-DRAIN -> cnt frozen, no rd_valid, still exactly 4 pulses total.
REQ-037 reset_n low during FILL after 2 words -> IDLE immediately, no done, cmd_ready=1 after release.
REQ-038 op 3 with SHIFT_REG_CTRL_ERR_EN -> err one cycle, no done; without macro -> err stays 0.

Source files
------------

// File: rtl/shift_reg_ctrl_if.sv
// rtl/shift_reg_ctrl_if.sv - command, fill-stream and drain-stream bundle of shift_reg_ctrl
// master drives commands and fill words; slave is the controller.
interface shift_reg_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic [1:0]            cmd_op;
  logic                  cmd_ready;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  done;
  logic                  err;

  modport master (
    output cmd_valid, cmd_op, wr_valid, wr_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, wr_valid, wr_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, err
  );
endinterface

// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - LOAD/DRAIN/FILL sequencer for an external LENGTH-word shift register
// Optional macro SHIFT_REG_CTRL_ERR_EN: illegal opcode 3 raises a one-cycle err pulse.
module shift_reg_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shift_reg_ctrl_if.slave       bus,
  output logic [1:0]            sr_ctrl_code,
  output logic [DATA_WIDTH-1:0] sr_data_write,
  input  logic [DATA_WIDTH-1:0] sr_data_read,
  input  logic                  sr_en
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

  localparam logic [1:0] SR_UPLOAD = 2'd0;
  localparam logic [1:0] SR_LOAD   = 2'd1;
  localparam logic [1:0] SR_WRITE  = 2'd2;
  localparam logic [1:0] SR_READ   = 2'd3;

`ifdef SHIFT_REG_CTRL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DRAIN_LAST,
    S_FILL,
    S_UPLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_valid_d;
  logic          cmd_ready;
  logic          wr_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    rd_valid_d    = 1'b0;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    sr_ctrl_code  = SR_UPLOAD;
    sr_data_write = bus.wr_data;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'd0:    state_d = S_LOAD;
            2'd1:    state_d = S_DRAIN;
            2'd2:    state_d = S_FILL;
            default: err_d   = ERR_EN;
          endcase
        end
      end
      S_LOAD: begin
        sr_ctrl_code = SR_LOAD;
        if (sr_en) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        sr_ctrl_code = SR_READ;
        if (sr_en) begin
          rd_valid_d = 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DRAIN_LAST;
          else                   cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DRAIN_LAST: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_FILL: begin
        wr_ready = sr_en;
        if (bus.wr_valid && sr_en) begin
          sr_ctrl_code = SR_WRITE;
          if (cnt_q == CNT_LAST) state_d = S_UPLD;
          else                   cnt_d   = cnt_q + CW'(1);
        end
      end
      S_UPLD: begin
        if (sr_en) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts from zero for every command.
    if (state_d == S_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // The shift register already registers its read word, so it lines up with rd_valid_q.
  assign bus.rd_data   = rd_valid_q ? sr_data_read : '0;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_ready  = wr_ready;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - randomized self-checking bench for shift_reg_ctrl
module tb_shift_reg_ctrl;
  localparam int DW  = 8;
  localparam int LEN = 4;
`ifdef SHIFT_REG_CTRL_ERR_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shift_reg_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  logic [1:0]    sr_ctrl_code;
  logic [DW-1:0] sr_data_write;
  logic [DW-1:0] sr_data_read;
  logic          sr_en;

  shift_reg_ctrl #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .sr_ctrl_code (sr_ctrl_code),
    .sr_data_write(sr_data_write),
    .sr_data_read (sr_data_read),
    .sr_en        (sr_en)
  );

  // Environment: the controlled shift register (LOAD parallel-loads, WRITE shifts in at the tail,
  // READ outputs the head and rotates so contents survive a drain).
  logic [DW-1:0] par_in [LEN];
  logic [DW-1:0] sr_mem [LEN];
  always @(posedge clk) begin
    if (sr_en) begin
      case (sr_ctrl_code)
        2'd1: for (int i = 0; i < LEN; i++) sr_mem[i] <= par_in[i];
        2'd2: begin
          for (int i = 0; i < LEN - 1; i++) sr_mem[i] <= sr_mem[i+1];
          sr_mem[LEN-1] <= sr_data_write;
        end
        2'd3: begin
          sr_data_read <= sr_mem[0];
          for (int i = 0; i < LEN - 1; i++) sr_mem[i] <= sr_mem[i+1];
          sr_mem[LEN-1] <= sr_mem[0];
        end
        default: ;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] fill_w [LEN];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input int en_pct, input bit use_pat, input logic [5:0] wv_pat);
    int done_n = 0, err_n = 0, rd_en = 0, ld_en = 0, cyc = 0, idx = 0;
    logic hs;
    logic [DW-1:0] got_q [$];
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.wr_valid  = 1'b0;
    tick();
    while (cyc < 400) begin
      bus.cmd_valid = 1'b0;
      bus.wr_valid  = 1'b0;
      if (bus.rd_valid) got_q.push_back(bus.rd_data);
      if (bus.err) err_n++;
      if (bus.done) begin
        done_n++;
        break;
      end
      if (op == 2'd3 && cyc == 3) break;
      sr_en = ($urandom_range(99) < en_pct);
      if (op == 2'd2) begin
        bus.wr_valid = use_pat ? wv_pat[cyc % 6] : 1'($urandom_range(1));
        bus.wr_data  = (idx < LEN) ? fill_w[idx] : DW'($urandom);
      end
      if (!bus.cmd_ready) begin
        bus.cmd_valid = 1'($urandom_range(1));
        bus.cmd_op    = 2'($urandom_range(3));
      end
      #1;
      if (op == 2'd2) begin
        hs = bus.wr_valid && bus.wr_ready;
        chk("write_on_handshake", sr_ctrl_code == 2'd2, hs);
        if (hs) idx++;
      end
      if (op == 2'd1 && sr_ctrl_code == 2'd3 && sr_en) rd_en++;
      if (op == 2'd0 && sr_ctrl_code == 2'd1 && sr_en) ld_en++;
      tick();
      cyc++;
    end
    chk("cmd_ready_after", bus.cmd_ready, 1);
    case (op)
      2'd0: begin
        chk("load_done", done_n, 1);
        chk("load_cycles", ld_en, 1);
        exp_q.delete();
        for (int i = 0; i < LEN; i++) exp_q.push_back(par_in[i]);
      end
      2'd1: begin
        chk("drain_done", done_n, 1);
        chk("drain_pulses", got_q.size(), LEN);
        chk("read_cycles", rd_en, LEN);
        for (int i = 0; i < LEN && i < got_q.size(); i++) chk("drain_data", got_q[i], exp_q[i]);
      end
      2'd2: begin
        chk("fill_done", done_n, 1);
        chk("fill_handshakes", idx, LEN);
        exp_q.delete();
        for (int i = 0; i < LEN; i++) exp_q.push_back(fill_w[i]);
      end
      default: begin
        chk("illegal_err", err_n, ERR_EXP);
        chk("illegal_no_done", done_n, 0);
      end
    endcase
    if (op != 2'd3) chk("err_spurious", err_n, 0);
    if (op != 2'd1) chk("rd_valid_spurious", got_q.size(), 0);
    sr_en = 1'($urandom_range(1));
    tick();
    chk("done_single", bus.done, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    sr_en         = 1'b1;
    repeat (2) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_code", sr_ctrl_code, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    reset_n = 1'b1;
    tick();

    par_in[0] = 8'hA; par_in[1] = 8'hB; par_in[2] = 8'hC; par_in[3] = 8'hD;
    run_cmd(2'd0, 100, 1'b0, 6'd0);
    run_cmd(2'd1, 100, 1'b0, 6'd0);
    fill_w[0] = 8'd11; fill_w[1] = 8'd22; fill_w[2] = 8'd33; fill_w[3] = 8'd44;
    run_cmd(2'd2, 100, 1'b1, 6'b101101);
    run_cmd(2'd1, 100, 1'b0, 6'd0);
    run_cmd(2'd1, 40, 1'b0, 6'd0);
    run_cmd(2'd3, 100, 1'b0, 6'd0);

    // Abort a FILL after two words with an asynchronous reset.
    sr_en = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    tick();
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'h5A;
    tick();
    bus.wr_data   = 8'hA5;
    tick();
    bus.wr_valid  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_done", bus.done, 0);
    chk("abort_wr_ready", bus.wr_ready, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("release_cmd_ready", bus.cmd_ready, 1);
    chk("release_done", bus.done, 0);

    for (int i = 0; i < LEN; i++) par_in[i] = DW'($urandom);
    run_cmd(2'd0, 100, 1'b0, 6'd0);
    run_cmd(2'd1, 70, 1'b0, 6'd0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(3));
      if (op == 2'd0) for (int i = 0; i < LEN; i++) par_in[i] = DW'($urandom);
      if (op == 2'd2) for (int i = 0; i < LEN; i++) fill_w[i] = DW'($urandom);
      run_cmd(op, $urandom_range(100, 30), 1'b0, 6'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
